fetch_pc_ctrl: RTL and testbench

Fetch-stage controller that owns the PC register and sequences instruction fetch for the pipelined MIPS core. It issues variable-latency requests to instruction memory and applies next-PC redirects from decode-stage branch/jump resolution with MIPS delay-slot semantics. It also holds a one-entry skid buffer and drives the F/D pipeline register under hazard stalls.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_skid.sv | 37 +++
 rtl/fetch_pc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the fetch-stage PC controller
// Revision  : 1.0  initial release
// ----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [4:0]  EXC_ADEL         = 5'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // One fetched instruction as it travels through the skid and F/D register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic addr_illegal(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_skid : one-entry buffer that catches a fetch completing while F/D stalls
// Revision   : 1.0  initial release
// ----------------------------------------------------------------------------
module fetch_skid
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_unload,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output fetch_entry_t o_entry
);

  logic         r_full;
  fetch_entry_t r_entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full  <= 1'b0;
      r_entry <= '0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_entry <= i_entry;
    end else if (i_unload) begin
      r_full  <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_entry = r_entry;

endmodule : fetch_skid
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pc_ctrl : PC owner and fetch sequencer with delay-slot redirects.
//                 Optional macro FETCH_EXC_EN adds AdEL fetch-address checking.
// Revision      : 1.0  initial release
// ----------------------------------------------------------------------------
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_MIN   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic        fd_exc,
  output logic [4:0]  fd_exccode
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_pend_valid;
  logic         w_pend_valid_nxt;
  logic [31:0]  r_pend_pc;
  logic [31:0]  w_pend_pc_nxt;

  logic         r_fd_valid;
  fetch_entry_t r_fd;
  fetch_entry_t w_fd_next;
  logic         w_fd_load;
  logic         w_fd_accept;

  logic         w_bad_addr;
  logic         w_ack;
  logic         w_im_req;
  fetch_entry_t w_fetch_entry;

  logic         w_skid_load;
  logic         w_skid_unload;
  logic         w_skid_full;
  fetch_entry_t w_skid_entry;

`ifdef FETCH_EXC_EN
  assign w_bad_addr = addr_illegal(r_pc, PC_MIN, PC_MAX);
  assign fd_exc     = r_fd.exc;
  assign fd_exccode = r_fd.exc ? EXC_ADEL : 5'd0;
`else
  logic w_unused_cfg;
  assign w_bad_addr   = 1'b0;
  assign fd_exc       = 1'b0;
  assign fd_exccode   = 5'd0;
  assign w_unused_cfg = ^{PC_MIN, PC_MAX, r_fd.exc};
`endif

  assign w_fd_accept = !r_fd_valid || !stall_d;

  // An illegal address never reaches memory; it completes internally as a nop.
  assign w_ack = (r_state == ST_FETCH) && (w_bad_addr || im_ack);

  assign w_fetch_entry.instr = w_bad_addr ? NOP_INSTR : im_rdata;
  assign w_fetch_entry.pc    = r_pc;
  assign w_fetch_entry.exc   = w_bad_addr;

  fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_entry  (w_fetch_entry),
    .o_full   (w_skid_full),
    .o_entry  (w_skid_entry)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    w_im_req         = 1'b0;
    w_fd_load        = 1'b0;
    w_fd_next        = w_fetch_entry;
    w_skid_load      = 1'b0;
    w_skid_unload    = 1'b0;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        w_im_req = !w_bad_addr;
        if (w_ack) begin
          if (w_fd_accept) begin
            w_fd_load = 1'b1;
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_HOLD;
          end
          if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
          end else if (r_pend_valid) begin
            w_pc_nxt = r_pend_pc;
          end else begin
            w_pc_nxt = pc_inc(r_pc);
          end
          w_pend_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          // The instruction still in flight is the delay slot; target comes after it.
          w_pend_valid_nxt = 1'b1;
          w_pend_pc_nxt    = redirect_pc;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end
        if (w_fd_accept) begin
          w_fd_load     = w_skid_full;
          w_fd_next     = w_skid_entry;
          w_skid_unload = 1'b1;
          w_state_nxt   = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= RESET_PC;
      r_fd_valid   <= 1'b0;
      r_fd         <= '{instr: NOP_INSTR, pc: RESET_PC, exc: 1'b0};
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      if (w_fd_accept) begin
        r_fd_valid <= w_fd_load;
        if (w_fd_load) begin
          r_fd <= w_fd_next;
        end
      end
    end
  end

  assign im_req   = w_im_req;
  assign im_addr  = r_pc;
  assign fd_valid = r_fd_valid;
  assign fd_instr = r_fd.instr;
  assign fd_pc    = r_fd.pc;

endmodule : fetch_pc_ctrl
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_pc_ctrl : randomized + directed bench for fetch_pc_ctrl against an
//                    instruction-stream model (delay-slot redirect semantics)
// Revision         : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_d = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic        fd_exc;
  logic [4:0]  fd_exccode;

  fetch_pc_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .fd_valid       (fd_valid),
    .fd_instr       (fd_instr),
    .fd_pc          (fd_pc),
    .fd_exc         (fd_exc),
    .fd_exccode     (fd_exccode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: the fetch stream is RESET_PC, +4, ... except where a branch
  // consumed at stream index k forces stream index k+2 to its target.
  logic [31:0] ovr [int];
  int fetch_cnt, cons, last_br, idle, cnt;
  logic busy, p_fd_valid, p_stall;

  // Knobs for directed stimulus.
  logic g_model, g_rand, g_stall, g_redir;
  logic [31:0] g_rpc;
  int g_lat;

  // Values sampled at the start of the most recent step.
  logic s_im_req, s_fd_valid, s_fd_exc;
  logic [31:0] s_im_addr, s_fd_pc, s_fd_instr;
  logic [4:0] s_fd_exccode;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pc_at(input int n);
    logic [31:0] p;
    p = 32'h0000_3000;
    for (int i = 1; i <= n; i++) p = ovr.exists(i) ? ovr[i] : p + 32'd4;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_init();
    ovr.delete();
    fetch_cnt = 0; cons = 0; last_br = -10; idle = 0; cnt = 0;
    busy = 1'b0; p_fd_valid = 1'b0; p_stall = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_im_req"},   {31'b0, im_req},   32'h0);
    chk({tag, "_im_addr"},  im_addr,           32'h0000_3000);
    chk({tag, "_fd_valid"}, {31'b0, fd_valid}, 32'h0);
    chk({tag, "_fd_instr"}, fd_instr,          32'h0);
    chk({tag, "_fd_pc"},    fd_pc,             32'h0000_3000);
    chk({tag, "_fd_exc"},   {27'b0, fd_exccode} | {31'b0, fd_exc}, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_init();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    stall_d = 1'b0; im_ack = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic step();
    logic stall, ack, do_redir;
    logic [31:0] rpc;
    int lat;
    @(negedge clk);
    s_im_req = im_req; s_im_addr = im_addr; s_fd_valid = fd_valid;
    s_fd_pc = fd_pc; s_fd_instr = fd_instr; s_fd_exc = fd_exc; s_fd_exccode = fd_exccode;
    if (g_model) begin
      if (s_im_req) chk("im_addr", s_im_addr, pc_at(fetch_cnt));
      if (s_fd_valid) begin
        chk("fd_pc", s_fd_pc, pc_at(cons));
        chk("fd_instr", s_fd_instr, mem_word(s_fd_pc));
        chk("fd_exc", {26'b0, s_fd_exccode, s_fd_exc}, 32'h0);
      end
      if (p_fd_valid && p_stall) chk("fd_hold", {31'b0, s_fd_valid}, 32'h1);
      if (idle > 40) begin
        chk("progress", idle, 32'h0);
        idle = 0;
      end
    end
    if (g_rand) begin
      stall = ($urandom_range(0, 3) == 0);
      lat   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      rpc   = $urandom_range(32'h0C00, 32'h1BFF) << 2;
    end else begin
      stall = g_stall;
      lat   = g_lat;
      rpc   = g_rpc;
    end
    if (s_im_req && !busy) begin
      busy = 1'b1;
      cnt  = lat;
    end
    ack = s_im_req && busy && (cnt == 0);
    do_redir = s_fd_valid && !stall && (cons != last_br + 1) &&
               (g_rand ? ($urandom_range(0, 4) == 0) : g_redir);
    stall_d        = stall;
    im_ack         = ack;
    im_rdata       = mem_word(s_im_addr);
    redirect_valid = do_redir;
    redirect_pc    = do_redir ? rpc : $urandom;
    @(posedge clk);
    if (!s_im_req) busy = 1'b0;
    else if (ack) begin
      fetch_cnt++;
      busy = 1'b0;
    end else if (busy) cnt--;
    if (do_redir) begin
      ovr[cons + 2] = rpc;
      last_br = cons;
    end
    if (s_fd_valid && !stall) begin
      cons++;
      idle = 0;
    end else idle++;
    p_fd_valid = s_fd_valid;
    p_stall = stall;
    g_redir = 1'b0;
  endtask

  initial begin
    g_model = 1'b1; g_rand = 1'b0; g_stall = 1'b0; g_redir = 1'b0;
    g_rpc = 32'h0; g_lat = 0;
    model_init();
    #1 reset = 1'b0;
    #1 chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    release_reset();

    // Zero-wait streaming and a branch with same-cycle ack of its delay slot.
    step(); chk("t1_req", {31'b0, s_im_req}, 32'h1); chk("t1_a0", s_im_addr, 32'h3000);
            chk("t1_fdv0", {31'b0, s_fd_valid}, 32'h0);
    step(); chk("t1_a1", s_im_addr, 32'h3004); chk("t1_fdv1", {31'b0, s_fd_valid}, 32'h1);
            chk("t1_pc0", s_fd_pc, 32'h3000);
    step(); chk("t1_a2", s_im_addr, 32'h3008); chk("t1_pc1", s_fd_pc, 32'h3004);
    g_redir = 1'b1; g_rpc = 32'h3100;
    step(); chk("t2_br", s_fd_pc, 32'h3008); chk("t2_ds_a", s_im_addr, 32'h300C);
    step(); chk("t2_ds", s_fd_pc, 32'h300C); chk("t2_tgt_a", s_im_addr, 32'h3100);
    step(); chk("t2_tgt", s_fd_pc, 32'h3100);

    // Redirect while the delay-slot fetch waits on slow memory.
    apply_reset();
    repeat (3) step();
    g_lat = 3; g_redir = 1'b1; g_rpc = 32'h3100;
    step(); chk("t3_a", s_im_addr, 32'h300C);
    g_lat = 0;
    step(); chk("t3_hold1", s_im_addr, 32'h300C); chk("t3_req1", {31'b0, s_im_req}, 32'h1);
    step(); chk("t3_hold2", s_im_addr, 32'h300C);
    step(); chk("t3_hold3", s_im_addr, 32'h300C);
    step(); chk("t3_tgt_a", s_im_addr, 32'h3100); chk("t3_ds", s_fd_pc, 32'h300C);
    step(); chk("t3_next_a", s_im_addr, 32'h3104); chk("t3_tgt", s_fd_pc, 32'h3100);

    // Stall while a fetch completes: instruction parks in the skid.
    g_stall = 1'b1;
    step(); chk("t4_a", s_im_addr, 32'h3108);
    step(); chk("t4_req", {31'b0, s_im_req}, 32'h0); chk("t4_fd", s_fd_pc, 32'h3104);
    step(); step();
    g_stall = 1'b0;
    step(); chk("t4_req2", {31'b0, s_im_req}, 32'h0);
    step(); chk("t4_skid", s_fd_pc, 32'h3108); chk("t4_res_a", s_im_addr, 32'h310C);
            chk("t4_res_req", {31'b0, s_im_req}, 32'h1);

    // Async reset in the middle of a fetch with a pending redirect.
    g_lat = 4; g_redir = 1'b1; g_rpc = 32'h3200;
    step(); chk("t5_a", s_im_addr, 32'h3110);
    step();
    #2 reset = 1'b0;
    stall_d = 1'b0; im_ack = 1'b0; redirect_valid = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    g_lat = 0;
    @(posedge clk);
    release_reset();
    step(); chk("t5_r0", s_im_addr, 32'h3000);
    step(); chk("t5_r1", s_im_addr, 32'h3004);
    step(); chk("t5_r2", s_im_addr, 32'h3008);

`ifdef FETCH_EXC_EN
    // Misaligned target: both it and its successor complete as AdEL nops.
    apply_reset();
    g_model = 1'b0;
    step();
    g_redir = 1'b1; g_rpc = 32'h3002;
    step(); chk("x_br", s_fd_pc, 32'h3000);
    step(); chk("x_noreq", {31'b0, s_im_req}, 32'h0); chk("x_ds", s_fd_pc, 32'h3004);
    step(); chk("x_pc", s_fd_pc, 32'h3002); chk("x_instr", s_fd_instr, 32'h0);
            chk("x_exc", {31'b0, s_fd_exc}, 32'h1); chk("x_code", {27'b0, s_fd_exccode}, 32'h4);
            chk("x_noreq2", {31'b0, s_im_req}, 32'h0);
    step(); chk("x_pc2", s_fd_pc, 32'h3006); chk("x_exc2", {31'b0, s_fd_exc}, 32'h1);
    g_model = 1'b1;
`endif

    // Randomized stalls, memory latency and redirects.
    apply_reset();
    g_rand = 1'b1;
    repeat (3000) step();
    g_rand = 1'b0;
    chk("rand_progress", {31'b0, (cons > 500)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_pc_ctrl
`default_nettype wire
